// File: rtl/jtgng_keymap.sv
// Purpose : turns hps_io PS/2 key events and two hps_io joysticks into the game core's active-low controls.
// Latency : a PS/2 event reaches the outputs two edges after it is seen; a joystick change reaches them one edge later.
// Backpr. : none; ps2_key, joy0 and joy1 are level/toggle inputs that are sampled on every clock.
//
// Ports:
//   clk, rst_n    system clock and asynchronous active-low reset
//   soft_rst      OSD/button reset; it clears only the pause state
//   ps2_key       [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
//   joy0, joy1    hps_io joysticks, active high
//   joystick1/2   active low {jump,fire,up,down,left,right}
//   start_button  active low {start2,start1}
//   coin_input    active low {coin2,coin1}; coin1 is stretched to COIN_CYCLES
//   pause_n       low while the game is paused
module jtgng_keymap #(
    parameter int unsigned COIN_CYCLES = 4800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joy0,
    input  logic [9:0]  joy1,
    output logic [5:0]  joystick1,
    output logic [5:0]  joystick2,
    output logic [1:0]  start_button,
    output logic [1:0]  coin_input,
    output logic        pause_n
);
    localparam int CW = 23;

    // One held flag per recognised key. Each fire key has its own flag, so
    // releasing one fire key never clears another one that is still held.
    typedef struct packed {
        logic up1, down1, left1, right1;
        logic ctrl_r, alt_r, ctrl_l, alt_l, jump1;
        logic start1, start2, coin, pause;
        logic up2, down2, left2, right2, fire2, jump2;
    } keys_t;

    keys_t           keys_q, keys_d;
    logic            old_tog_q, old_tog_d;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            coin_prev_q, coin_prev_d;
    logic            pause_q, pause_d;
    logic            pause_prev_q, pause_prev_d;
    logic [5:0]      joystick1_q, joystick1_d;
    logic [5:0]      joystick2_q, joystick2_d;
    logic [1:0]      start_q, start_d;
    logic            coin1_n_q, coin1_n_d;

    logic            key_evt;
    logic            pressed;
    logic [7:0]      code;
    logic [5:0]      p1_m, p2_m;
    logic [1:0]      start_m;
    logic            coin_m, pause_m;

    assign pressed = ps2_key[9];
    assign code    = ps2_key[7:0];

    always_comb begin
        keys_d    = keys_q;
        old_tog_d = ps2_key[10];
        // The first cycle after reset only captures the toggle level, so a
        // toggle that is already high at reset release does not look like an event.
        armed_d   = 1'b1;
        key_evt   = armed_q && (ps2_key[10] != old_tog_q);

        if (key_evt) begin
            if (ps2_key[8]) begin
                case (code)
                    8'h75:   keys_d.up1    = pressed;
                    8'h72:   keys_d.down1  = pressed;
                    8'h6B:   keys_d.left1  = pressed;
                    8'h74:   keys_d.right1 = pressed;
                    8'h14:   keys_d.ctrl_r = pressed;
                    8'h11:   keys_d.alt_r  = pressed;
                    default: ;
                endcase
            end else begin
                case (code)
                    8'h14:   keys_d.ctrl_l = pressed;
                    8'h11:   keys_d.alt_l  = pressed;
                    8'h29:   keys_d.jump1  = pressed;
                    8'h05:   keys_d.start1 = pressed;
                    8'h06:   keys_d.start2 = pressed;
                    8'h04:   keys_d.coin   = pressed;
                    8'h0C:   keys_d.pause  = pressed;
                    8'h2D:   keys_d.up2    = pressed;
                    8'h2B:   keys_d.down2  = pressed;
                    8'h23:   keys_d.left2  = pressed;
                    8'h34:   keys_d.right2 = pressed;
                    8'h1C:   keys_d.fire2  = pressed;
                    8'h1B:   keys_d.jump2  = pressed;
                    default: ;
                endcase
            end
        end

        // Joystick bit order [5:0] already matches {jump,fire,up,down,left,right}.
        p1_m = {keys_q.jump1,
                keys_q.ctrl_r | keys_q.alt_r | keys_q.ctrl_l | keys_q.alt_l,
                keys_q.up1, keys_q.down1, keys_q.left1, keys_q.right1} | joy0[5:0];
        p2_m = {keys_q.jump2, keys_q.fire2,
                keys_q.up2, keys_q.down2, keys_q.left2, keys_q.right2} | joy1[5:0];
        start_m = {keys_q.start2, keys_q.start1} | joy0[7:6] | joy1[7:6];
        coin_m  = keys_q.coin  | joy0[8] | joy1[8];
        pause_m = keys_q.pause | joy0[9] | joy1[9];

        // A coin only starts a pulse from idle. Edges during a pulse are
        // dropped, so the pulse is never retriggered or extended.
        coin_prev_d = coin_m;
        if (coin_m && !coin_prev_q && (cnt_q == '0)) begin
            cnt_d = CW'(COIN_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // soft_rst wins over a pause edge in the same cycle.
        pause_prev_d = pause_m;
        if (soft_rst) begin
            pause_d = 1'b0;
        end else if (pause_m && !pause_prev_q) begin
            pause_d = ~pause_q;
        end else begin
            pause_d = pause_q;
        end

        joystick1_d = ~p1_m;
        joystick2_d = ~p2_m;
        start_d     = ~start_m;
        coin1_n_d   = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q       <= '0;
            old_tog_q    <= 1'b0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            coin_prev_q  <= 1'b0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
            joystick1_q  <= 6'h3F;
            joystick2_q  <= 6'h3F;
            start_q      <= 2'b11;
            coin1_n_q    <= 1'b1;
        end else begin
            keys_q       <= keys_d;
            old_tog_q    <= old_tog_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            coin_prev_q  <= coin_prev_d;
            pause_q      <= pause_d;
            pause_prev_q <= pause_prev_d;
            joystick1_q  <= joystick1_d;
            joystick2_q  <= joystick2_d;
            start_q      <= start_d;
            coin1_n_q    <= coin1_n_d;
        end
    end

    assign joystick1    = joystick1_q;
    assign joystick2    = joystick2_q;
    assign start_button = start_q;
    assign coin_input   = {1'b1, coin1_n_q};
    assign pause_n      = ~pause_q;

endmodule
